riscv_mc_ctrl: RTL and testbench

Multi-cycle main control FSM for the RV32I core. It succeeds the single-cycle opcode decoder with a sequenced controller that drives a shared instruction/data memory port through a ready handshake. It also traps on illegal opcodes and, optionally, on memory timeouts, and counts retired instructions. It sits between the instruction register (opcode) and the multi-cycle datapath.

---
 rtl/riscv_mc_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_riscv_mc_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I main control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory port. Optional memory-wait timeout trap: RISCV_MC_TIMEOUT_EN.
module riscv_mc_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             branch,
    output logic [1:0]       ALUsrcA,
    output logic [1:0]       ALUsrcB,
    output logic [1:0]       ALUop,
    output logic             RegWrite,
    output logic [1:0]       writeSelect,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, EXEC_AUIPC, ADDR, MEM_RD, MEM_WR,
        WB_ALU, WB_MEM, WB_IMM, BRANCH, JAL, JALR, TRAP
    } state_t;

    state_t state, nxt;
    logic   mem_state;
    logic   wait_expired;

    assign mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);

`ifdef RISCV_MC_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    logic [7:0] wcnt;

    // Any cycle not spent waiting clears the counter, so each memory state starts from 0.
    assign wait_expired = mem_state && !mem_ready && (wcnt == WAIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            if (mem_state && !mem_ready)
                wcnt <= wcnt + 8'd1;
            else
                wcnt <= '0;
            if (wait_expired)
                timeout <= 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_comb begin
        nxt = state;
        case (state)
            FETCH:      nxt = mem_ready ? DECODE : (wait_expired ? TRAP : FETCH);
            DECODE: begin
                case (opcode)
                    7'b0110011:             nxt = EXEC_R;
                    7'b0010011:             nxt = EXEC_I;
                    7'b0010111:             nxt = EXEC_AUIPC;
                    7'b0110111:             nxt = WB_IMM;
                    7'b0000011, 7'b0100011: nxt = ADDR;
                    7'b1100011:             nxt = BRANCH;
                    7'b1101111:             nxt = JAL;
                    7'b1100111:             nxt = JALR;
                    default:                nxt = TRAP;
                endcase
            end
            EXEC_R, EXEC_I, EXEC_AUIPC: nxt = WB_ALU;
            ADDR:       nxt = opcode[5] ? MEM_WR : MEM_RD;
            MEM_RD:     nxt = mem_ready ? WB_MEM : (wait_expired ? TRAP : MEM_RD);
            MEM_WR:     nxt = mem_ready ? FETCH  : (wait_expired ? TRAP : MEM_WR);
            WB_ALU, WB_MEM, WB_IMM, BRANCH, JAL, JALR: nxt = FETCH;
            TRAP:       nxt = TRAP;
            default:    nxt = TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state <= nxt;
            if (state == DECODE && nxt == TRAP)
                illegal <= 1'b1;
            if (state != FETCH && nxt == FETCH)
                retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        branch      = 1'b0;
        ALUsrcA     = 2'b00;
        ALUsrcB     = 2'b00;
        ALUop       = 2'b00;
        RegWrite    = 1'b0;
        writeSelect = 2'b00;
        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
                ALUsrcB  = 2'b01;
            end
            DECODE, EXEC_AUIPC: begin
                ALUsrcA = 2'b10;
                ALUsrcB = 2'b10;
            end
            EXEC_R: begin
                ALUsrcA = 2'b01;
                ALUop   = 2'b10;
            end
            EXEC_I: begin
                ALUsrcA = 2'b01;
                ALUsrcB = 2'b10;
                ALUop   = 2'b11;
            end
            ADDR: begin
                ALUsrcA = 2'b01;
                ALUsrcB = 2'b10;
            end
            MEM_RD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
            end
            MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
            end
            WB_ALU: RegWrite = 1'b1;
            WB_MEM: begin
                RegWrite    = 1'b1;
                writeSelect = 2'b01;
            end
            WB_IMM: begin
                RegWrite    = 1'b1;
                writeSelect = 2'b11;
            end
            BRANCH: begin
                ALUsrcA = 2'b01;
                ALUop   = 2'b01;
                branch  = 1'b1;
                pc_src  = 2'b01;
            end
            JAL: begin
                pc_write    = 1'b1;
                pc_src      = 2'b01;
                RegWrite    = 1'b1;
                writeSelect = 2'b10;
            end
            JALR: begin
                ALUsrcA     = 2'b01;
                ALUsrcB     = 2'b10;
                pc_write    = 1'b1;
                pc_src      = 2'b10;
                RegWrite    = 1'b1;
                writeSelect = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: the driver pushes hand-derived per-cycle
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_riscv_mc_ctrl;

    typedef enum {S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_AUIPC, S_ADDR, S_MEM_RD,
                  S_MEM_WR, S_WB_ALU, S_WB_MEM, S_WB_IMM, S_BRANCH, S_JAL, S_JALR, S_TRAP} st_e;

    typedef struct packed {
        logic       req, we, as, irw, pcw;
        logic [1:0] pcs;
        logic       br;
        logic [1:0] a, b, op;
        logic       rw;
        logic [1:0] ws;
    } ctl_t;

    typedef struct {
        ctl_t        ctl;
        logic        ill;
        logic        to;
        logic [31:0] ret;
        string       nm;
    } exp_t;

    logic        clk, reset, mem_ready;
    logic [6:0]  opcode;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write, branch, RegWrite;
    logic [1:0]  pc_src, ALUsrcA, ALUsrcB, ALUop, writeSelect;
    logic        illegal, timeout;
    logic [31:0] retired;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    riscv_mc_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .branch(branch), .ALUsrcA(ALUsrcA),
        .ALUsrcB(ALUsrcB), .ALUop(ALUop), .RegWrite(RegWrite), .writeSelect(writeSelect),
        .illegal(illegal), .timeout(timeout), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control table: req we as irw pcw pcs br a b op rw ws
    function automatic ctl_t ctl_of(input st_e s, input logic rdy);
        case (s)
            S_FETCH:      return {1'b1, 1'b0, 1'b0, rdy,  rdy,  2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 2'b00};
            S_DECODE:     return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 2'b00};
            S_EXEC_R:     return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 2'b10, 1'b0, 2'b00};
            S_EXEC_I:     return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b10, 2'b11, 1'b0, 2'b00};
            S_EXEC_AUIPC: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 2'b00};
            S_ADDR:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b10, 2'b00, 1'b0, 2'b00};
            S_MEM_RD:     return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00};
            S_MEM_WR:     return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00};
            S_WB_ALU:     return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00};
            S_WB_MEM:     return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01};
            S_WB_IMM:     return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b11};
            S_BRANCH:     return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b01, 2'b00, 2'b01, 1'b0, 2'b00};
            S_JAL:        return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10};
            S_JALR:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b01, 2'b10, 2'b00, 1'b1, 2'b10};
            default:      return '0;
        endcase
    endfunction

    // Drive one cycle's inputs just after the edge and queue what that cycle must show.
    task automatic step(input st_e s, input logic rdy, input logic rst, input logic ill,
                        input logic to, input int unsigned ret, input string nm);
        exp_t e;
        reset     = rst;
        mem_ready = rdy;
        e.ctl = ctl_of(s, rdy);
        e.ill = ill;
        e.to  = to;
        e.ret = ret;
        e.nm  = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        ctl_t act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, branch,
                   ALUsrcA, ALUsrcB, ALUop, RegWrite, writeSelect};
            n_cmp++;
            if (act !== e.ctl || illegal !== e.ill || timeout !== e.to || retired !== e.ret) begin
                n_err++;
                $display("FAIL %s: got ctl=%05h ill=%b to=%b ret=%0d, want ctl=%05h ill=%b to=%b ret=%0d",
                         e.nm, act, illegal, timeout, retired, e.ctl, e.ill, e.to, e.ret);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; mem_ready = 1'b0; opcode = 7'b0;
        @(posedge clk); #1;
        step(S_FETCH, 0, 0, 0, 0, 0, "rst.hold0");
        step(S_FETCH, 1, 0, 0, 0, 0, "rst.hold1");

        opcode = 7'b0110011;
        step(S_FETCH,  1, 1, 0, 0, 0, "add.f");
        step(S_DECODE, 0, 1, 0, 0, 0, "add.d");
        step(S_EXEC_R, 0, 1, 0, 0, 0, "add.x");
        step(S_WB_ALU, 0, 1, 0, 0, 0, "add.wb");

        opcode = 7'b0000011;
        step(S_FETCH,  1, 1, 0, 0, 1, "lw.f");
        step(S_DECODE, 0, 1, 0, 0, 1, "lw.d");
        step(S_ADDR,   0, 1, 0, 0, 1, "lw.a");
        step(S_MEM_RD, 0, 1, 0, 0, 1, "lw.m0");
        step(S_MEM_RD, 0, 1, 0, 0, 1, "lw.m1");
        step(S_MEM_RD, 0, 1, 0, 0, 1, "lw.m2");
        step(S_MEM_RD, 1, 1, 0, 0, 1, "lw.m3");
        step(S_WB_MEM, 0, 1, 0, 0, 1, "lw.wb");

        opcode = 7'b0100011;
        step(S_FETCH,  1, 1, 0, 0, 2, "sw.f");
        step(S_DECODE, 0, 1, 0, 0, 2, "sw.d");
        step(S_ADDR,   0, 1, 0, 0, 2, "sw.a");
        step(S_MEM_WR, 1, 1, 0, 0, 2, "sw.m");

        opcode = 7'b1100111;
        step(S_FETCH,  1, 1, 0, 0, 3, "jalr.f");
        step(S_DECODE, 0, 1, 0, 0, 3, "jalr.d");
        step(S_JALR,   0, 1, 0, 0, 3, "jalr.x");

        opcode = 7'b1101111;
        step(S_FETCH,  1, 1, 0, 0, 4, "jal.f");
        step(S_DECODE, 0, 1, 0, 0, 4, "jal.d");
        step(S_JAL,    0, 1, 0, 0, 4, "jal.x");
        opcode = 7'b1100011;
        step(S_FETCH,  1, 1, 0, 0, 5, "beq.f");
        step(S_DECODE, 0, 1, 0, 0, 5, "beq.d");
        step(S_BRANCH, 0, 1, 0, 0, 5, "beq.x");

        opcode = 7'b0110111;
        step(S_FETCH,  1, 1, 0, 0, 6, "lui.f");
        step(S_DECODE, 0, 1, 0, 0, 6, "lui.d");
        step(S_WB_IMM, 0, 1, 0, 0, 6, "lui.wb");

        opcode = 7'b0010011;
        step(S_FETCH,  1, 1, 0, 0, 7, "addi.f");
        step(S_DECODE, 0, 1, 0, 0, 7, "addi.d");
        step(S_EXEC_I, 0, 1, 0, 0, 7, "addi.x");
        step(S_WB_ALU, 0, 1, 0, 0, 7, "addi.wb");

        opcode = 7'b0010111;
        step(S_FETCH,      1, 1, 0, 0, 8, "auipc.f");
        step(S_DECODE,     0, 1, 0, 0, 8, "auipc.d");
        step(S_EXEC_AUIPC, 0, 1, 0, 0, 8, "auipc.x");
        step(S_WB_ALU,     0, 1, 0, 0, 8, "auipc.wb");

        // Reset lands in the middle of a stalled store.
        opcode = 7'b0100011;
        step(S_FETCH,  1, 1, 0, 0, 9, "swr.f");
        step(S_DECODE, 0, 1, 0, 0, 9, "swr.d");
        step(S_ADDR,   0, 1, 0, 0, 9, "swr.a");
        step(S_MEM_WR, 0, 1, 0, 0, 9, "swr.m");
        step(S_FETCH,  0, 0, 0, 0, 0, "swr.rst");
        step(S_FETCH,  0, 0, 0, 0, 0, "swr.hold");

        opcode = 7'b0110111;
`ifdef RISCV_MC_TIMEOUT_EN
        step(S_FETCH,  0, 1, 0, 0, 0, "to.w0");
        step(S_FETCH,  0, 1, 0, 0, 0, "to.w1");
        step(S_FETCH,  0, 1, 0, 0, 0, "to.w2");
        step(S_FETCH,  1, 1, 0, 0, 0, "to.edge_ok");
        step(S_DECODE, 0, 1, 0, 0, 0, "to.d");
        step(S_WB_IMM, 0, 1, 0, 0, 0, "to.wb");
        step(S_FETCH,  0, 1, 0, 0, 1, "to.x0");
        step(S_FETCH,  0, 1, 0, 0, 1, "to.x1");
        step(S_FETCH,  0, 1, 0, 0, 1, "to.x2");
        step(S_FETCH,  0, 1, 0, 0, 1, "to.x3");
        step(S_TRAP,   1, 1, 0, 1, 1, "to.trap0");
        step(S_TRAP,   0, 1, 0, 1, 1, "to.trap1");
        step(S_FETCH,  0, 0, 0, 0, 0, "to.rst");
`else
        for (int i = 0; i < 100; i++)
            step(S_FETCH, 0, 1, 0, 0, 0, $sformatf("nowait.%0d", i));
`endif

        opcode = 7'b0000000;
        step(S_FETCH,  1, 1, 0, 0, 0, "ill.f");
        step(S_DECODE, 0, 1, 0, 0, 0, "ill.d");
        step(S_TRAP,   1, 1, 1, 0, 0, "ill.t0");
        step(S_TRAP,   0, 1, 1, 0, 0, "ill.t1");
        step(S_TRAP,   1, 1, 1, 0, 0, "ill.t2");
        step(S_FETCH,  0, 0, 0, 0, 0, "ill.rst");
        opcode = 7'b0110111;
        step(S_FETCH,  1, 1, 0, 0, 0, "ill.resume");
        step(S_DECODE, 0, 1, 0, 0, 0, "ill.d2");
        step(S_WB_IMM, 0, 1, 0, 0, 0, "ill.wb");
        step(S_FETCH,  0, 1, 0, 0, 1, "ill.end");

        @(negedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
